// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Control unit for a multicycle MIPS-style datapath. A Moore FSM walks each
//   instruction through FETCH/DECODE and the per-class execute states, and
//   decodes the state into datapath selects and write strobes.
//
// Ports
//   CLK, RSTn        : clock, synchronous active-low reset
//   Opcode, Funct    : instruction fields from the instruction register
//   Zero             : ALU zero flag (branch resolution)
//   MemReady         : memory handshake, access completes in the cycle it is high
//   IorD .. ALUSrcA  : 1-bit datapath selects and write strobes
//   ALUSrcB, PCSrc   : 2-bit operand-B and next-PC selects
//   PCEn, ALUSel     : PC write enable, ALU function
//   State            : current state code
//   InstrDone        : pulse on the last cycle of every instruction
//   IllegalOp        : pulse in DECODE when the opcode is not recognised
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int AWL = 6
) (
    input  logic           CLK,
    input  logic           RSTn,
    input  logic [AWL-1:0] Opcode,
    input  logic [AWL-1:0] Funct,
    input  logic           Zero,
    input  logic           MemReady,
    output logic           IorD,
    output logic           IRWE,
    output logic           DMWE,
    output logic           MtoRFSel,
    output logic           RFDSel,
    output logic           RFWE,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     PCSrc,
    output logic           PCEn,
    output logic [AWL-3:0] ALUSel,
    output logic [3:0]     State,
    output logic           InstrDone,
    output logic           IllegalOp
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

    localparam logic [AWL-1:0] OP_R    = AWL'(6'b000000);
    localparam logic [AWL-1:0] OP_LW   = AWL'(6'b100011);
    localparam logic [AWL-1:0] OP_SW   = AWL'(6'b101011);
    localparam logic [AWL-1:0] OP_BEQ  = AWL'(6'b000100);
    localparam logic [AWL-1:0] OP_ADDI = AWL'(6'b001000);
    localparam logic [AWL-1:0] OP_J    = AWL'(6'b000010);

    localparam logic [AWL-1:0] FN_ADD = AWL'(6'b100000);
    localparam logic [AWL-1:0] FN_SUB = AWL'(6'b100010);
    localparam logic [AWL-1:0] FN_AND = AWL'(6'b100100);
    localparam logic [AWL-1:0] FN_OR  = AWL'(6'b100101);
    localparam logic [AWL-1:0] FN_SLT = AWL'(6'b101010);

    localparam logic [AWL-3:0] ALU_AND = (AWL-2)'(4'b0000);
    localparam logic [AWL-3:0] ALU_OR  = (AWL-2)'(4'b0001);
    localparam logic [AWL-3:0] ALU_ADD = (AWL-2)'(4'b0010);
    localparam logic [AWL-3:0] ALU_SUB = (AWL-2)'(4'b0110);
    localparam logic [AWL-3:0] ALU_SLT = (AWL-2)'(4'b0111);

    state_e state_q, state_d;

    // Ungated strobes; reset masking is applied at the output
    logic irwe_c, pcen_c, dmwe_c, rfwe_c, done_c, illegal_c;

    always_ff @(posedge CLK) begin
        if (!RSTn) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = FETCH;
        IorD      = 1'b0;
        MtoRFSel  = 1'b0;
        RFDSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        ALUSel    = '0;
        irwe_c    = 1'b0;
        pcen_c    = 1'b0;
        dmwe_c    = 1'b0;
        rfwe_c    = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB = 2'b01;
                ALUSel  = ALU_ADD;
                irwe_c  = MemReady;
                pcen_c  = MemReady;
                state_d = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is computed here so BEQ only needs the compare
                ALUSrcB = 2'b11;
                ALUSel  = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUSel  = ALU_ADD;
                state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                rfwe_c   = 1'b1;
                MtoRFSel = 1'b1;
                done_c   = 1'b1;
            end
            MEMWR: begin
                IorD    = 1'b1;
                dmwe_c  = MemReady;
                done_c  = MemReady;
                state_d = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                state_d = ALUWB;
                case (Funct)
                    FN_SUB:  ALUSel = ALU_SUB;
                    FN_AND:  ALUSel = ALU_AND;
                    FN_OR:   ALUSel = ALU_OR;
                    FN_SLT:  ALUSel = ALU_SLT;
                    FN_ADD:  ALUSel = ALU_ADD;
                    default: ALUSel = ALU_ADD;
                endcase
            end
            ALUWB: begin
                rfwe_c = 1'b1;
                RFDSel = 1'b1;
                done_c = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 1'b1;
                ALUSel  = ALU_SUB;
                PCSrc   = 2'b01;
                pcen_c  = Zero;
                done_c  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUSel  = ALU_ADD;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                rfwe_c = 1'b1;
                done_c = 1'b1;
            end
            JUMP: begin
                PCSrc  = 2'b10;
                pcen_c = 1'b1;
                done_c = 1'b1;
            end
            // Unused codes fall back to FETCH with everything low
            default: state_d = FETCH;
        endcase
    end

    // Strobes are killed while reset is held so a mid-instruction reset
    // cannot commit a register or memory write
    assign IRWE      = irwe_c    & RSTn;
    assign PCEn      = pcen_c    & RSTn;
    assign DMWE      = dmwe_c    & RSTn;
    assign RFWE      = rfwe_c    & RSTn;
    assign InstrDone = done_c    & RSTn;
    assign IllegalOp = illegal_c & RSTn;
    assign State     = state_q;

endmodule
